// File: rtl/wave_capture_pkg.sv
// rtl/wave_capture_pkg.sv - shared types for the trigger-based capture buffer
// Purpose: capture FSM state encoding used by wave_capture.
// Ports: none (package).
package wave_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port sample RAM with registered read
// Purpose: one frame of sample storage; one write port, one registered read port.
// Ports: clk, rst_n (async active-low, clears the read register only),
//        we/waddr/wdata (write port), raddr (read address), rdata (read data, 1-cycle latency).
module capture_ram #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  import wave_capture_pkg::*;

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is never reset so a frame survives an abandoned capture.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register samples the pre-write contents on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - armed, level-triggered single-frame sample capture
// Purpose: waits for a rising crossing of trig_level (or force_trig), then stores
//          2**ADDRESS_WIDTH consecutive strobed samples for later readback.
// Ports: clk, rst_n (async active-low), en/din (sample strobe and data), arm (start pulse),
//        force_trig (immediate trigger while armed), trig_level (unsigned threshold),
//        rd_addr/dout (registered readback), busy, done, wr_count (samples in current frame).
module wave_capture #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     arm,
  input  logic                     force_trig,
  input  logic [DATA_WIDTH-1:0]    trig_level,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   wr_count
);
  import wave_capture_pkg::*;

  localparam logic [ADDRESS_WIDTH:0] FRAME_LEN = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] ONE       = (ADDRESS_WIDTH + 1)'(1);

  cap_state_t                 state;
  logic [DATA_WIDTH-1:0]      prev;
  logic                       prev_valid;
  logic                       crossing;
  logic                       trig_hit;
  logic                       we;
  logic [ADDRESS_WIDTH-1:0]   waddr;
  logic [ADDRESS_WIDTH:0]     wr_count_inc;

  // The very first sample after arming has no predecessor, so only force_trig can fire it.
  assign crossing     = prev_valid && (prev < trig_level) && (din >= trig_level);
  assign trig_hit     = en && (crossing || force_trig);
  assign wr_count_inc = wr_count + ONE;

  // The triggering sample itself lands at address 0.
  assign we    = ((state == ARMED) && trig_hit) || ((state == CAPTURE) && en);
  assign waddr = (state == CAPTURE) ? wr_count[ADDRESS_WIDTH-1:0] : '0;

  assign busy = (state == ARMED) || (state == CAPTURE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev       <= '0;
      prev_valid <= 1'b0;
      wr_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wr_count   <= '0;
          prev_valid <= 1'b0;
          if (arm) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (en) begin
            prev       <= din;
            prev_valid <= 1'b1;
            if (trig_hit) begin
              wr_count <= ONE;
              state    <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          // en gaps simply stall; the MSB of wr_count marks a full frame.
          if (en) begin
            wr_count <= wr_count_inc;
            if (wr_count_inc == FRAME_LEN) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (arm) begin
            wr_count   <= '0;
            prev_valid <= 1'b0;
            state      <= ARMED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  capture_ram #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(waddr),
    .wdata(din),
    .raddr(rd_addr),
    .rdata(dout)
  );

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - self-checking scoreboard bench for wave_capture
module tb_wave_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] din;
  logic       arm;
  logic       force_trig;
  logic [7:0] trig_level;
  logic [7:0] rd_addr;
  logic [7:0] dout;
  logic       busy;
  logic       done;
  logic [8:0] wr_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_ram [256];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  wave_capture #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .arm       (arm),
    .force_trig(force_trig),
    .trig_level(trig_level),
    .rd_addr   (rd_addr),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard read: expectation is queued as the address is driven, compared when dout updates.
  task automatic read_check(input string tag, input logic [7:0] addr);
    rd_addr = addr;
    exp_q.push_back(model_ram[addr]);
    step();
    check(tag, dout, exp_q.pop_front());
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    int n_en;
    int wa;
    logic [7:0] a;
    logic trig_seen;

    rst_n = 1'b0; en = 1'b0; din = '0; arm = 1'b0; force_trig = 1'b0;
    trig_level = 8'h80; rd_addr = '0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wr_count", wr_count, 0);
    check("reset_dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Ramp trigger: crossing at 0x80, frame wraps back to 0x7F.
    pulse_arm();
    check("ramp_armed_busy", busy, 1);
    n_en = 0;
    trig_seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      din = 8'(i);
      en  = 1'b1;
      if (i >= 128) model_ram[8'(i - 128)] = 8'(i);
      step();
      n_en++;
      if (i == 127) check("ramp_no_trig_below", wr_count, 0);
      if (i == 128) begin
        check("ramp_trig_wr_count", wr_count, 1);
        trig_seen = 1'b1;
      end
      if (done) break;
    end
    en = 1'b0;
    check("ramp_trig_seen", trig_seen, 1);
    check("ramp_en_count", n_en, 384);
    check("ramp_done", done, 1);
    check("ramp_busy_off", busy, 0);
    check("ramp_wr_count_full", wr_count, 256);
    read_check("ramp_rd0", 8'd0);
    read_check("ramp_rd255", 8'd255);
    read_check("ramp_rd5", 8'd5);
    step();
    check("done_holds", done, 1);

    // Rearm from DONE; constant level above threshold never crosses.
    pulse_arm();
    check("rearm_busy", busy, 1);
    check("rearm_done", done, 0);
    check("rearm_wr_count", wr_count, 0);
    for (int i = 0; i < 10; i++) begin
      din = 8'h90; en = 1'b1;
      step();
    end
    check("const_no_trig_busy", busy, 1);
    check("const_no_trig_count", wr_count, 0);
    din = 8'hFF; step();
    din = 8'h10; step();
    en = 1'b0;
    check("falling_no_trig", wr_count, 0);
    check("falling_still_armed", busy, 1);

    // force_trig is ignored until a strobe arrives.
    force_trig = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("force_no_en_count", wr_count, 0);
    check("force_no_en_busy", busy, 1);
    din = 8'h22; en = 1'b1;
    model_ram[0] = 8'h22;
    step();
    en = 1'b0; force_trig = 1'b0;
    check("force_trig_count", wr_count, 1);
    check("force_trig_busy", busy, 1);
    read_check("force_rd0", 8'd0);

    // Strobe every third cycle with a stray arm; every cycle reads back through the scoreboard,
    // and en cycles read the address being written to confirm old-data read-during-write.
    wa = 1;
    for (int c = 0; c < 300 && wa < 37; c++) begin
      en  = (c % 3 == 2);
      din = 8'h40 + 8'(c);
      arm = (c == 10);
      a   = en ? 8'(wa) : 8'(wa - 1);
      rd_addr = a;
      exp_q.push_back(model_ram[a]);
      if (en) begin
        model_ram[8'(wa)] = din;
        wa++;
      end
      step();
      check("gap_dout", dout, exp_q.pop_front());
      check("gap_wr_count", wr_count, wa);
    end
    en = 1'b0; arm = 1'b0;
    check("gap_reached_37", wr_count, 37);
    check("gap_busy", busy, 1);
    check("gap_not_done", done, 0);

    // Asynchronous reset mid-capture; RAM keeps its contents.
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_wr_count", wr_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    read_check("post_reset_rd5", 8'd5);
    read_check("post_reset_rd0", 8'd0);
    read_check("post_reset_rd200", 8'd200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
